// File: rtl/regbank_uva16.sv
// Operand register bank and Gray-coded subcycle sequencer for the DSPuva16 core.
// Captures S/T(K)/D operands and commits write-back and Z/N/V flags once per cycle.
//
// state | meaning
// PH0   | subcycle 0 (00)
// PH1   | subcycle 1 (01)
// PH2   | subcycle 2 (11), the edge leaving it is the cycle edge
// PH3   | subcycle 3 (10), core loads InA/InB/InC
module regbank_uva16 #(
  parameter int NREGS = 16,
  parameter int W     = 24,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_nreset,
  input  logic          i_enable,
  output logic [1:0]    o_phase,
  input  logic [AW-1:0] i_addr_s,
  input  logic [AW-1:0] i_addr_t,
  input  logic [AW-1:0] i_addr_d,
  input  logic          i_zero_s,
  input  logic          i_use_k,
  input  logic [15:0]   i_k,
  output logic [W-1:0]  o_in_a,
  output logic [W-1:0]  o_in_b,
  output logic [W-1:0]  o_in_c,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_flag_wr,
  input  logic          i_vin,
  input  logic [1:0]    i_flag_sel,
  output logic          o_flag_in
);

  typedef enum logic [1:0] {
    PH0 = 2'b00,
    PH1 = 2'b01,
    PH2 = 2'b11,
    PH3 = 2'b10
  } phase_t;

  phase_t       r_phase;
  phase_t       w_phase_nxt;
  logic         w_cycle_edge;
  logic [W-1:0] r_regs [NREGS];
  logic [W-1:0] r_in_a, r_in_b, r_in_c;
  logic         r_z, r_n, r_v;
  logic [W-1:0] w_rd_s, w_rd_t, w_rd_d;

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_phase <= PH0;
    end else if (i_enable) begin
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_phase_nxt  = PH0;
    w_cycle_edge = 1'b0;
    case (r_phase)
      PH0: w_phase_nxt = PH1;
      PH1: w_phase_nxt = PH2;
      PH2: begin
        w_phase_nxt  = PH3;
        w_cycle_edge = i_enable;
      end
      PH3: w_phase_nxt = PH0;
      default: w_phase_nxt = PH0;
    endcase
  end

  // Same-edge write-back is forwarded to all three read ports.
  always_comb begin
    w_rd_s = (i_wr_en && (i_wr_addr == i_addr_s)) ? i_wr_data : r_regs[i_addr_s];
    w_rd_t = (i_wr_en && (i_wr_addr == i_addr_t)) ? i_wr_data : r_regs[i_addr_t];
    w_rd_d = (i_wr_en && (i_wr_addr == i_addr_d)) ? i_wr_data : r_regs[i_addr_d];
  end

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_in_a <= '0;
      r_in_b <= '0;
      r_in_c <= '0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_v    <= 1'b0;
    end else if (w_cycle_edge) begin
      r_in_a <= i_zero_s ? '0 : w_rd_s;
      r_in_b <= i_use_k ? {i_k, {(W-16){1'b0}}} : w_rd_t;
      r_in_c <= w_rd_d;
      if (i_wr_en) begin
        r_regs[i_wr_addr] <= i_wr_data;
      end
      // Flags update even without a register write (compare-only).
      if (i_flag_wr) begin
        r_z <= (i_wr_data[W-1:W-16] == 16'h0000);
        r_n <= i_wr_data[W-1];
        r_v <= i_vin;
      end
    end
  end

  always_comb begin
    o_flag_in = 1'b1;
    case (i_flag_sel)
      2'b00:   o_flag_in = r_z;
      2'b01:   o_flag_in = r_n;
      2'b10:   o_flag_in = r_v;
      default: o_flag_in = 1'b1;
    endcase
  end

  assign o_phase = r_phase;
  assign o_in_a  = r_in_a;
  assign o_in_b  = r_in_b;
  assign o_in_c  = r_in_c;

endmodule

// File: tb/tb_regbank_uva16.sv
// Self-checking bench for regbank_uva16: directed scenarios plus random traffic
// compared against a cycle-count/array reference model.
module tb_regbank_uva16;

  logic        clk = 1'b0;
  logic        nreset, en;
  logic [1:0]  phase;
  logic [3:0]  as, at, ad, wa;
  logic        zs, uk, we, fw, vin;
  logic [15:0] k;
  logic [23:0] ina, inb, inc, wd;
  logic [1:0]  fsel;
  logic        flagin;

  always #5 clk = ~clk;

  regbank_uva16 dut (
    .i_clk(clk), .i_nreset(nreset), .i_enable(en), .o_phase(phase),
    .i_addr_s(as), .i_addr_t(at), .i_addr_d(ad), .i_zero_s(zs),
    .i_use_k(uk), .i_k(k), .o_in_a(ina), .o_in_b(inb), .o_in_c(inc),
    .i_wr_en(we), .i_wr_addr(wa), .i_wr_data(wd), .i_flag_wr(fw),
    .i_vin(vin), .i_flag_sel(fsel), .o_flag_in(flagin)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: subcycle count 0..3, register array, operand and flag values.
  int          m_pidx;
  logic [23:0] m_regs [16];
  logic [23:0] m_a, m_b, m_c;
  logic        m_z, m_n, m_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gray_of(input int i);
    case (i)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [23:0] m_rd(input logic [3:0] x);
    if (we && wa == x) return wd;
    return m_regs[x];
  endfunction

  function automatic logic m_flag(input logic [1:0] sel);
    case (sel)
      2'b00: return m_z;
      2'b01: return m_n;
      2'b10: return m_v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!nreset) begin
      m_pidx = 0;
      for (int i = 0; i < 16; i++) m_regs[i] = 24'h0;
      m_a = 0; m_b = 0; m_c = 0;
      m_z = 0; m_n = 0; m_v = 0;
    end else if (en) begin
      if (m_pidx == 2) begin
        m_a = zs ? 24'h0 : m_rd(as);
        m_b = uk ? {k, 8'h00} : m_rd(at);
        m_c = m_rd(ad);
        if (we) m_regs[wa] = wd;
        if (fw) begin
          m_z = (wd[23:8] == 16'h0);
          m_n = wd[23];
          m_v = vin;
        end
      end
      m_pidx = (m_pidx + 1) % 4;
    end
    #1;
    check("phase", {30'h0, phase}, {30'h0, gray_of(m_pidx)});
    check("in_a", {8'h0, ina}, {8'h0, m_a});
    check("in_b", {8'h0, inb}, {8'h0, m_b});
    check("in_c", {8'h0, inc}, {8'h0, m_c});
    check("flag_in", {31'h0, flagin}, {31'h0, m_flag(fsel)});
  endtask

  task automatic idle_inputs();
    as = 0; at = 0; ad = 0; wa = 0; zs = 0; uk = 0; k = 0;
    we = 0; fw = 0; vin = 0; wd = 0;
  endtask

  // Advance with Enable=1 until the model sits in ph2, so the next tick is a cycle edge.
  task automatic to_ph2();
    en = 1'b1;
    for (int i = 0; i < 8 && m_pidx != 2; i++) tick();
    check("reach_ph2", {30'h0, phase}, 32'h3);
  endtask

  initial begin
    nreset = 1'b0; en = 1'b0; fsel = 2'b11;
    idle_inputs();
    tick();
    check("rst_flagin_const1", {31'h0, flagin}, 32'h1);
    nreset = 1'b1; en = 1'b1;

    // Gray sequence from reset.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("gray_seq", {30'h0, phase}, {30'h0, gray_of((i + 1) % 4)});
    end
    tick();
    en = 1'b0;
    repeat (3) begin
      tick();
      check("stall_ph1", {30'h0, phase}, 32'h1);
    end
    en = 1'b1;

    // Write then read through the array.
    to_ph2();
    we = 1; wa = 5; wd = 24'h53A200;
    tick();
    we = 0;
    to_ph2();
    as = 5; at = 5; ad = 5;
    tick();
    check("rd5_a", {8'h0, ina}, 32'h53A200);
    check("rd5_b", {8'h0, inb}, 32'h53A200);
    check("rd5_c", {8'h0, inc}, 32'h53A200);

    // Same-edge bypass.
    to_ph2();
    we = 1; wa = 3; wd = 24'h111100;
    tick();
    to_ph2();
    wd = 24'hDB1F00; as = 3; ad = 3; at = 0;
    tick();
    check("byp_a", {8'h0, ina}, 32'hDB1F00);
    check("byp_c", {8'h0, inc}, 32'hDB1F00);
    we = 0;
    to_ph2();
    tick();
    check("arr3_a", {8'h0, ina}, 32'hDB1F00);

    // Stall in ph2 defers the cycle edge.
    to_ph2();
    en = 0; as = 5;
    repeat (3) tick();
    check("stall_ph2_hold", {8'h0, ina}, 32'hDB1F00);
    en = 1;
    tick();
    check("stall_ph2_cap", {8'h0, ina}, 32'h53A200);

    // Immediate and zero source.
    to_ph2();
    uk = 1; k = 16'h6B1F; zs = 1;
    tick();
    check("imm_b", {8'h0, inb}, 32'h6B1F00);
    check("zero_a", {8'h0, ina}, 32'h0);
    uk = 0; zs = 0;

    // Flags, compare-only update.
    to_ph2();
    fw = 1; wd = 24'h0000FF; vin = 1;
    tick();
    fw = 0;
    fsel = 2'b00; #1 check("flag_z1", {31'h0, flagin}, 32'h1);
    fsel = 2'b01; #1 check("flag_n0", {31'h0, flagin}, 32'h0);
    fsel = 2'b10; #1 check("flag_v1", {31'h0, flagin}, 32'h1);
    to_ph2();
    fw = 1; wd = 24'h800000; vin = 0;
    tick();
    fw = 0;
    fsel = 2'b00; #1 check("flag_z0", {31'h0, flagin}, 32'h0);
    fsel = 2'b01; #1 check("flag_n1", {31'h0, flagin}, 32'h1);
    fsel = 2'b10; #1 check("flag_v0", {31'h0, flagin}, 32'h0);
    fsel = 2'b11; #1 check("flag_one", {31'h0, flagin}, 32'h1);

    // Reset at ph3 during a pending write to reg7.
    to_ph2();
    tick();
    we = 1; wa = 7; wd = 24'hABCDEF; as = 7;
    nreset = 0;
    tick();
    check("rst_phase", {30'h0, phase}, 32'h0);
    check("rst_a", {8'h0, ina}, 32'h0);
    nreset = 1; we = 0; uk = 1; k = 16'h1234;
    tick();
    tick();
    check("rst_nocap2", {8'h0, inb}, 32'h0);
    tick();
    check("rst_cap3", {8'h0, inb}, 32'h123400);
    check("rst_reg7", {8'h0, ina}, 32'h0);
    idle_inputs();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      nreset = ($urandom_range(0, 63) != 0);
      en     = ($urandom_range(0, 7) != 0);
      as = 4'($urandom); at = 4'($urandom); ad = 4'($urandom); wa = 4'($urandom);
      zs = ($urandom_range(0, 5) == 0);
      uk = ($urandom_range(0, 3) == 0);
      k  = 16'($urandom);
      we = $urandom_range(0, 1) == 1;
      fw = $urandom_range(0, 2) == 0;
      vin = $urandom_range(0, 1) == 1;
      wd = 24'($urandom);
      if ($urandom_range(0, 7) == 0) wd[23:8] = 16'h0;
      fsel = 2'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/regbank_uva16.md
# regbank_uva16

Operand register bank and subcycle sequencer for the DSPuva16 core, sitting directly upstream of the computation core. It generates the four-subcycle Phase sequence and holds sixteen 24-bit data registers. Once per instruction cycle it presents operands S, T (or immediate K) and D on registered outputs InA/InB/InC, in time for the core's ph3 operand load. It also commits write-back results and maintains the Z/N/V flag register that drives the core's FlagIn.

## Interface
- NREGS, 16, number of data registers (power of two; address width = log2(NREGS))
- W, 24, data width (16-bit value in [23:8], 8 guard/fraction bits in [7:0])
- Clk  in  1  DSP clock; all state changes on rising edge
- nReset  in  1  reset, synchronous and active-low
- Enable  in  1  1 = advance; 0 = freeze all state (stall)
- Phase  out  2  subcycle id, Gray order ph0=00, ph1=01, ph2=11, ph3=10
- AddrS, AddrT, AddrD  in  4  source/source/destination register indexes
- ZeroS  in  1  force InA = 0 instead of reg[AddrS]
- UseK  in  1  select immediate for InB
- K  in  16  immediate; InB = {K, 8'h00}
- InA, InB, InC  out  W  registered operands S, T/K, D to the computation core
- WrEn  in  1  write-back request
- WrAddr  in  4  write-back register index
- WrData  in  W  write-back value
- FlagWr  in  1  update Z/N/V with this write-back
- Vin  in  1  overflow from the arithmetic ALU
- FlagSel  in  2  00 Z, 01 N, 10 V, 11 constant 1
- FlagIn  out  1  selected flag, combinational from flag register and FlagSel

## Operation
- Phase counter: 2-bit Gray sequence 00→01→11→10→00, one step per Clk while Enable=1; holds while Enable=0.
- "Cycle edge" = rising Clk with Enable=1 and Phase=ph2 (the edge entering ph3). Only cycle edges capture operands or commit writes.
- Operand capture at cycle edge:
  - InA ← ZeroS ? 0 : rd(AddrS)
  - InB ← UseK ? {K,8'h00} : rd(AddrT)
  - InC ← rd(AddrD)
  - Outputs hold for the following 4 Enable cycles.
- Write-back at cycle edge: if WrEn, reg[WrAddr] ← WrData. All NREGS registers are writable; there is no hardwired zero register (ZeroS provides 0).
- Bypass: rd(x) = (WrEn && WrAddr==x) ? WrData : reg[x]. A read of the register being written on the same cycle edge returns the new value. This applies independently to S, T and D, including all three at once.
- Flags at cycle edge when FlagWr=1:
  - Z ← (WrData[23:8]==0); guard bits are ignored.
  - N ← WrData[23]
  - V ← Vin
  - FlagWr=1 with WrEn=0 still updates the flags (compare-only).
- Flags hold otherwise. FlagIn reflects a flag update immediately after the edge that updates it.
- Inputs sampled outside cycle edges are ignored.

## Timing
- Reset (nReset=0 at a rising edge, regardless of Enable) forces:
  - Phase=00, all registers 0, InA=InB=InC=0, Z=N=V=0.
  - FlagIn then equals the value selected by FlagSel (FlagSel=11 → 1).
- Reset mid-cycle (any phase) aborts the cycle; no partial write occurs. The first cycle edge after release is the 3rd Enable edge (00→01→11→edge).
- Operand latency: AddrS/T/D and WrData presented during ph2 appear on InA/InB/InC after the ph2→ph3 edge, valid throughout ph3 when the core loads them.
- Stall: Enable=0 during ph2 defers the cycle edge. No capture or write occurs until Enable returns high with Phase still ph2.
- Write-to-read: a value written at cycle edge n is visible through bypass at edge n and through the array from edge n+1 on.

## Test plan
- Reset then 8 edges with Enable=1 → Phase 00,01,11,10,00,01,11,10; Enable=0 for 3 edges at ph1 → Phase stays 01.
- Write reg5=24'h53A200 at one cycle edge, then at the next edge AddrS=5, AddrT=5, AddrD=5 → InA=InB=InC=24'h53A200.
- Same-edge bypass: reg3 holds 24'h111100; WrEn=1, WrAddr=3, WrData=24'hDB1F00, AddrS=3, AddrD=3 → InA=InC=24'hDB1F00; the next cycle reads 24'hDB1F00 from the array.
- UseK=1, K=16'h6B1F, ZeroS=1 → InB=24'h6B1F00, InA=24'h000000.
- FlagWr=1, WrData=24'h0000FF, Vin=1 → Z=1, N=0, V=1; FlagSel=00→FlagIn=1, 01→0, 10→1; a later FlagWr with WrData=24'h800000, Vin=0 → Z=0, N=1, V=0.
- nReset=0 at ph3 during a pending write to reg7 → reg7 reads 0, InA/InB/InC=0, Phase=00; the first capture occurs at the 3rd edge after release.
